// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, state encodings and ALU op codes for the multi-cycle controller
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_ADD = 2'b01;
    localparam logic [1:0] ALUOP_OR  = 2'b11;

    // True for every opcode the datapath can execute
    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_R) || (op == OP_ADDI) || (op == OP_ORI) ||
               (op == OP_LW) || (op == OP_SW);
    endfunction

    // True for the opcodes that visit the MEM state
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unanswered MEM cycles and flags the last one allowed
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [W-1:0] LAST = W'(MEM_WAIT_MAX - 1);

    logic [W-1:0] cnt;

    // Wait counter: cleared before each MEM visit, advances on every cycle without ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

    // The current MEM cycle is the final one the controller will wait through
    assign expire = (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath selects and strobes
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Opcode,
    input  logic             Mem_ready,
    output logic             PC_w,
    output logic             IR_w,
    output logic             Reg_w,
    output logic             Mem_r,
    output logic             Mem_w,
    output logic             Reg_dst,
    output logic             ALU_src,
    output logic             Mem_to_reg,
    output logic [1:0]       ALU_op,
    output logic [2:0]       State,
    output logic             Illegal,
    output logic             Mem_err,
    output logic [CNT_W-1:0] Instr_cnt
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       expire;
    logic       in_mem;

    assign in_mem = (state_q == S_MEM);
    assign State  = state_q;

    mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == S_EXEC),
        .enable(in_mem && !Mem_ready),
        .expire(expire)
    );

    // State register, latched opcode and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            Instr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= Opcode;
            end
            if (PC_w) begin
                Instr_cnt <= Instr_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and strobes; PC_w/Mem_err leaving MEM react to Mem_ready in the same cycle
    always_comb begin
        state_d = state_q;
        PC_w    = 1'b0;
        IR_w    = 1'b0;
        Reg_w   = 1'b0;
        Mem_r   = 1'b0;
        Mem_w   = 1'b0;
        Illegal = 1'b0;
        Mem_err = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                IR_w    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_supported(Opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    Illegal = 1'b1;
                    PC_w    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: state_d = is_mem_op(op_q) ? S_MEM : S_WB;
            S_MEM: begin
                Mem_r = (op_q == OP_LW);
                Mem_w = (op_q == OP_SW);
                if (Mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        PC_w    = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (expire) begin
                    Mem_err = 1'b1;
                    PC_w    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                Reg_w   = 1'b1;
                PC_w    = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath selects follow the latched opcode only while the instruction is executing
    always_comb begin
        Reg_dst    = 1'b0;
        ALU_src    = 1'b0;
        Mem_to_reg = 1'b0;
        ALU_op     = 2'b00;
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (op_q)
                OP_R: begin
                    Reg_dst = 1'b1;
                    ALU_op  = ALUOP_R;
                end
                OP_ADDI: begin
                    ALU_src = 1'b1;
                    ALU_op  = ALUOP_ADD;
                end
                OP_ORI: begin
                    ALU_src = 1'b1;
                    ALU_op  = ALUOP_OR;
                end
                OP_LW: begin
                    ALU_src    = 1'b1;
                    Mem_to_reg = 1'b1;
                    ALU_op     = ALUOP_ADD;
                end
                OP_SW: begin
                    ALU_src = 1'b1;
                    ALU_op  = ALUOP_ADD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;

    localparam int MAXW = 4;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    Opcode;
    logic          Mem_ready;
    logic          PC_w, IR_w, Reg_w, Mem_r, Mem_w, Reg_dst, ALU_src, Mem_to_reg;
    logic [1:0]    ALU_op;
    logic [2:0]    State;
    logic          Illegal, Mem_err;
    logic [CW-1:0] Instr_cnt;

    multicycle_ctrl #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Mem_ready(Mem_ready),
        .PC_w(PC_w), .IR_w(IR_w), .Reg_w(Reg_w), .Mem_r(Mem_r), .Mem_w(Mem_w),
        .Reg_dst(Reg_dst), .ALU_src(ALU_src), .Mem_to_reg(Mem_to_reg), .ALU_op(ALU_op),
        .State(State), .Illegal(Illegal), .Mem_err(Mem_err), .Instr_cnt(Instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_w, pc_w, reg_w, mem_r, mem_w, reg_dst, alu_src, mem_to_reg;
        logic [1:0] alu_op;
        logic       illegal, mem_err;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        int         wait_n;
        int         cycles;
    } case_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc_no = 0;
    logic [CW-1:0] model_cnt = '0;
    vec_t          act;

    assign act = '{State, IR_w, PC_w, Reg_w, Mem_r, Mem_w, Reg_dst, ALU_src, Mem_to_reg,
                   ALU_op, Illegal, Mem_err};

    // Instruction-class properties: what each supported opcode asks of the datapath
    function automatic vec_t sel(input logic [5:0] op);
        vec_t v = '0;
        case (op)
            6'b000000: begin v.reg_dst = 1; v.alu_op = 2'b10; end
            6'b001000: begin v.alu_src = 1; v.alu_op = 2'b01; end
            6'b001101: begin v.alu_src = 1; v.alu_op = 2'b11; end
            6'b100011: begin v.alu_src = 1; v.mem_to_reg = 1; v.alu_op = 2'b01; end
            6'b101011: begin v.alu_src = 1; v.alu_op = 2'b01; end
            default: ;
        endcase
        return v;
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b001000 || op == 6'b001101 ||
               op == 6'b100011 || op == 6'b101011;
    endfunction

    task automatic step(input logic [5:0] op, input logic mr, input logic rst, input vec_t e);
        @(negedge clk);
        rst_n = rst;
        Opcode = op;
        Mem_ready = mr;
        #1;
        cyc_no++;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got %b required %b (st,ir,pc,reg,mr,mw,dst,src,m2r,aluop,ill,err)",
                     cyc_no, act, e);
        end
        checks++;
        if (Instr_cnt !== model_cnt) begin
            errors++;
            $display("FAIL instr_cnt cycle %0d: got %0d required %0d", cyc_no, Instr_cnt, model_cnt);
        end
        if (!rst) model_cnt = '0;
        else if (e.pc_w) model_cnt = model_cnt + 1'b1;
    endtask

    // Expand one instruction into its expected cycle sequence; MEM ready comes after wait_n idle cycles
    task automatic run_instr(input logic [5:0] op, input int wait_n, output int cyc);
        vec_t e;
        bit   ld, st, rdy, done;
        ld = (op == 6'b100011);
        st = (op == 6'b101011);
        cyc = 0;
        e = '0; e.st = 3'd1; e.ir_w = 1;
        step(6'($urandom), 1'($urandom), 1'b1, e); cyc++;
        e = '0; e.st = 3'd2;
        if (!legal(op)) begin e.illegal = 1; e.pc_w = 1; end
        step(op, 1'($urandom), 1'b1, e); cyc++;
        if (!legal(op)) return;
        e = sel(op); e.st = 3'd3;
        step(6'($urandom), 1'($urandom), 1'b1, e); cyc++;
        if (ld || st) begin
            done = 0;
            for (int i = 0; i < MAXW && !done; i++) begin
                rdy = (i == wait_n);
                e = sel(op); e.st = 3'd4; e.mem_r = ld; e.mem_w = st;
                if (rdy && st) e.pc_w = 1;
                if (!rdy && i == MAXW - 1) begin e.mem_err = 1; e.pc_w = 1; end
                step(6'($urandom), rdy, 1'b1, e); cyc++;
                if (rdy || i == MAXW - 1) begin
                    done = 1;
                    if (!rdy || st) return;
                end
            end
        end
        e = sel(op); e.st = 3'd5; e.reg_w = 1; e.pc_w = 1;
        step(6'($urandom), 1'($urandom), 1'b1, e); cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        model_cnt = '0;
        step(6'($urandom), 1'($urandom), 1'b1, vec_t'(0));
    endtask

    case_t tab[10];
    int    cyc;
    vec_t  e;
    logic [5:0] rop;

    initial begin
        rst_n = 1'b0;
        Opcode = '0;
        Mem_ready = 1'b0;

        tab[0] = '{6'b001000, 0, 4};
        tab[1] = '{6'b100011, 2, 7};
        tab[2] = '{6'b101011, 0, 4};
        tab[3] = '{6'b000010, 0, 2};
        tab[4] = '{6'b100011, 9, 7};
        tab[5] = '{6'b100011, 3, 8};
        tab[6] = '{6'b001101, 0, 4};
        tab[7] = '{6'b000000, 0, 4};
        tab[8] = '{6'b101011, 9, 7};
        tab[9] = '{6'b101011, 3, 7};

        do_reset();
        for (int k = 0; k < 10; k++) begin
            run_instr(tab[k].op, tab[k].wait_n, cyc);
            checks++;
            if (cyc != tab[k].cycles) begin
                errors++;
                $display("FAIL cycles case %0d: got %0d required %0d", k, cyc, tab[k].cycles);
            end
        end

        // Reset during the second MEM cycle of a store
        e = '0; e.st = 3'd1; e.ir_w = 1; step(6'($urandom), 1'b0, 1'b1, e);
        e = '0; e.st = 3'd2; step(6'b101011, 1'b0, 1'b1, e);
        e = sel(6'b101011); e.st = 3'd3; step(6'($urandom), 1'b0, 1'b1, e);
        e = sel(6'b101011); e.st = 3'd4; e.mem_w = 1; step(6'($urandom), 1'b0, 1'b1, e);
        step(6'($urandom), 1'b0, 1'b0, e);
        step(6'($urandom), 1'b0, 1'b1, vec_t'(0));
        run_instr(6'b000000, 0, cyc);

        // Random instruction mix, including illegal opcodes, timeouts and counter wrap
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 6))
                0: rop = 6'b000000;
                1: rop = 6'b001000;
                2: rop = 6'b001101;
                3, 4: rop = 6'b100011;
                5: rop = 6'b101011;
                default: rop = 6'($urandom);
            endcase
            run_instr(rop, int'($urandom_range(0, 5)), cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
